instruction_fetcher: RTL
========================

// Module: instruction_fetcher
// PURPOSE
//  Front end that produces the instruction stream consumed by the reorder buffer's issue port.
//  Holds the PC, requests words from instruction memory and launches one instruction per
//  accepted cycle (if_ins_launch_flag/if_ins/if_ins_pc). Throttled by rob_full.
//  Redirects on rob_flush and stalls on JALR until its commit supplies the target.
// PARAMETERS
//  RESET_PC    32'h0  PC loaded on reset
//  BHT_BITS    6      log2 of branch-history entries (used only with FETCH_BHT_EN)
// PORTS
//  clk                input   1   clock, rising edge
//  rst_n              input   1   asynchronous reset, active-low
//  rdy                input   1   global enable; when 0, all state frozen
//  imem_req           output  1   memory read request, held until imem_valid
//  imem_addr          output  32  word address = pc
//  imem_valid         input   1   read data valid, one-cycle pulse, latency >=1
//  imem_data          input   32  instruction word
//  rob_full           input   1   ROB cannot accept; no launch while high
//  if_ins_launch_flag output  1   one-cycle launch pulse
//  if_ins             output  32  launched instruction
//  if_ins_pc          output  32  PC of launched instruction
//  if_pred_taken      output  1   prediction used for launched branch
//  rob_flush          input   1   mispredict flush; highest priority
//  flush_pc           input   32  correct next PC on flush
//  commit_flag        input   1   ROB commit broadcast valid
//  commit_is_jalr     input   1   committed entry is JALR
//  commit_value       input   32  JALR target when commit_is_jalr
//  br_update_flag     input   1   branch resolved (BHT training)
//  br_update_pc       input   32  PC of resolved branch
//  br_update_taken    input   1   actual outcome
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, imem_req=0, if_ins_launch_flag=0,
//   if_ins=0, if_ins_pc=0, if_pred_taken=0, BHT counters=2'b01.
//  States: FETCH -> WAIT -> (HOLD) -> FETCH | JWAIT; DRAIN.
//   FETCH: imem_req=1, imem_addr=pc; next WAIT.
//   WAIT: on imem_valid latch word; if !rob_full launch same cycle edge, else HOLD.
//   HOLD: keep word; launch on first cycle with rob_full=0.
//   Launch: if_ins_launch_flag=1 for exactly one cycle, if_ins/if_ins_pc valid with it.
//  Next PC at launch (opcode = ins[6:0]):
//   JAL 1101111: pc+sext(J-imm); BRANCH 1100011: predicted-taken ? pc+sext(B-imm) : pc+4;
//   JALR 1100111: go JWAIT, no further fetch; other: pc+4. Arithmetic mod 2^32.
//  JWAIT: wait commit_flag && commit_is_jalr; pc<=commit_value, state FETCH.
//   At most one JALR in flight by construction.
//  rob_flush (any state): pc<=flush_pc; launch suppressed that cycle; held word dropped.
//   If a memory request is outstanding (WAIT) -> DRAIN: wait imem_valid, discard, FETCH.
//   Else -> FETCH next cycle. Flush wins over simultaneous imem_valid/commit/launch.
//  imem_req deasserts the cycle after imem_valid; never two outstanding requests.
//  rdy=0: no state/output change; launch pulse not repeated when rdy returns.
// CONFIGURATION
//  FETCH_BHT_EN defined: 2^BHT_BITS 2-bit saturating counters indexed pc[BHT_BITS+1:2];
//   predict taken when counter[1]=1; br_update_flag increments (taken) / decrements,
//   saturating at 3/0; update and lookup same index same cycle -> lookup sees old value.
//  FETCH_BHT_EN undefined: static not-taken; if_pred_taken=0; br_update_* ignored.
// TESTING
//  1 Reset, RESET_PC=0, mem ADDI at 0,4 -> launches pc 0 then 4, one pulse each.
//  2 rob_full=1 while word at 0x8 returns -> no launch; drop full after 3 cyc -> launch
//    pc 0x8 next edge, exactly once.
//  3 JALR at 0x10 -> no fetch of 0x14; commit_is_jalr value 0x100 -> next fetch 0x100.
//  4 rob_flush flush_pc=0x200 during WAIT -> late imem_valid discarded, next launch pc 0x200.
//  5 JAL imm=+0x40 at 0x20 -> next launched pc 0x60; BEQ at 0x30 (no BHT) -> next 0x34.
//  6 FETCH_BHT_EN: two taken updates for 0x30 -> BEQ imm +8 launches if_pred_taken=1,
//    next pc 0x38; rst_n low mid-WAIT -> all outputs 0, pc=RESET_PC immediately.

Source files
------------

// File: rtl/instruction_fetcher_if.sv
// Fetch-unit bus bundle: instruction memory port, ROB issue port and ROB feedback signals.
// The fetcher connects through the master modport; memory/ROB models use the slave modport.
interface instruction_fetcher_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        rob_full;
  logic        if_ins_launch_flag;
  logic [31:0] if_ins;
  logic [31:0] if_ins_pc;
  logic        if_pred_taken;
  logic        rob_flush;
  logic [31:0] flush_pc;
  logic        commit_flag;
  logic        commit_is_jalr;
  logic [31:0] commit_value;
  logic        br_update_flag;
  logic [31:0] br_update_pc;
  logic        br_update_taken;

  modport master (
    output imem_req, imem_addr, if_ins_launch_flag, if_ins, if_ins_pc, if_pred_taken,
    input  imem_valid, imem_data, rob_full, rob_flush, flush_pc, commit_flag, commit_is_jalr,
           commit_value, br_update_flag, br_update_pc, br_update_taken
  );

  modport slave (
    input  imem_req, imem_addr, if_ins_launch_flag, if_ins, if_ins_pc, if_pred_taken,
    output imem_valid, imem_data, rob_full, rob_flush, flush_pc, commit_flag, commit_is_jalr,
           commit_value, br_update_flag, br_update_pc, br_update_taken
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetch front end: PC, one outstanding imem request, one launch per accepted word.
// Define FETCH_BHT_EN for a 2-bit-counter branch history table; otherwise static not-taken.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned BHT_BITS = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   rdy,
  instruction_fetcher_if.master bus
);

  typedef enum logic [2:0] {StFetch, StWait, StHold, StJwait, StDrain} state_e;

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] word_q, word_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] ins_pc_q, ins_pc_d;
  logic        req_q, req_d;
  logic        launch_q, launch_d;
  logic        pred_q, pred_d;

  logic [31:0] cur_word, j_imm, b_imm;
  logic        bht_taken, br_taken, do_launch;

  always_comb begin
    cur_word = (state_q == StHold) ? word_q : bus.imem_data;
    j_imm    = {{12{cur_word[31]}}, cur_word[19:12], cur_word[20], cur_word[30:21], 1'b0};
    b_imm    = {{20{cur_word[31]}}, cur_word[7], cur_word[30:25], cur_word[11:8], 1'b0};
    br_taken = (cur_word[6:0] == OpBranch) && bht_taken;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    word_d    = word_q;
    req_d     = req_q;
    launch_d  = 1'b0;
    ins_d     = ins_q;
    ins_pc_d  = ins_pc_q;
    pred_d    = pred_q;
    do_launch = 1'b0;

    if (bus.imem_valid) req_d = 1'b0;

    unique case (state_q)
      StFetch: begin
        req_d   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (bus.imem_valid) begin
          if (!bus.rob_full) begin
            do_launch = 1'b1;
          end else begin
            word_d  = bus.imem_data;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (!bus.rob_full) do_launch = 1'b1;
      end
      StJwait: begin
        if (bus.commit_flag && bus.commit_is_jalr) begin
          pc_d    = bus.commit_value;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (bus.imem_valid) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (do_launch) begin
      launch_d = 1'b1;
      ins_d    = cur_word;
      ins_pc_d = pc_q;
      pred_d   = br_taken;
      state_d  = StFetch;
      case (cur_word[6:0])
        OpJal:    pc_d = pc_q + j_imm;
        OpBranch: pc_d = br_taken ? pc_q + b_imm : pc_q + 32'd4;
        OpJalr:   state_d = StJwait;
        default:  pc_d = pc_q + 32'd4;
      endcase
    end

    // Flush overrides everything; a request still in flight must be drained before refetching.
    if (bus.rob_flush) begin
      pc_d     = bus.flush_pc;
      launch_d = 1'b0;
      ins_d    = ins_q;
      ins_pc_d = ins_pc_q;
      pred_d   = pred_q;
      if ((state_q == StWait || state_q == StDrain) && !bus.imem_valid) begin
        state_d = StDrain;
        req_d   = 1'b1;
      end else begin
        state_d = StFetch;
        req_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      word_q   <= '0;
      req_q    <= 1'b0;
      launch_q <= 1'b0;
      ins_q    <= '0;
      ins_pc_q <= '0;
      pred_q   <= 1'b0;
    end else if (rdy) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      word_q   <= word_d;
      req_q    <= req_d;
      launch_q <= launch_d;
      ins_q    <= ins_d;
      ins_pc_q <= ins_pc_d;
      pred_q   <= pred_d;
    end
  end

`ifdef FETCH_BHT_EN
  localparam int unsigned BhtEntries = 2 ** BHT_BITS;

  logic [1:0]          bht_q [BhtEntries];
  logic [BHT_BITS-1:0] look_idx, upd_idx;

  assign look_idx  = pc_q[BHT_BITS+1:2];
  assign upd_idx   = bus.br_update_pc[BHT_BITS+1:2];
  assign bht_taken = bht_q[look_idx][1];

  // Lookup reads the registered counter, so a same-cycle update is seen only afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_q <= '{default: 2'b01};
    end else if (rdy && bus.br_update_flag) begin
      if (bus.br_update_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else if (bht_q[upd_idx] != 2'b00) begin
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end

  logic unused_bht;
  assign unused_bht = ^{bus.br_update_pc[31:BHT_BITS+2], bus.br_update_pc[1:0]};
`else
  localparam int unsigned UnusedBhtBits = BHT_BITS;

  logic unused_bht;
  assign bht_taken  = 1'b0;
  assign unused_bht = ^{bus.br_update_flag, bus.br_update_pc, bus.br_update_taken};
`endif

  assign bus.imem_req           = req_q;
  assign bus.imem_addr          = pc_q;
  assign bus.if_ins_launch_flag = launch_q;
  assign bus.if_ins             = ins_q;
  assign bus.if_ins_pc          = ins_pc_q;
  assign bus.if_pred_taken      = pred_q;

endmodule
